load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Execute/memory-stage block directly downstream of the integer ALU.
- Consumes the ALU sum (base + offset) as the effective address, plus the store data, funct3 and destination register.
- Runs one data-memory transaction at a time over a valid/ready request and valid response bus.
- Returns sign/zero-extended load data to writeback and stalls the pipeline via req_ready while busy.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported (byte lanes fixed at 4).
- TIMEOUT_CYCLES, 255, response watchdog limit; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a load/store.
- req_ready  out  1  LSU idle and can accept; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign field.
- req_addr  in  DATA_WIDTH  effective address from the ALU output.
- req_wdata  in  DATA_WIDTH  rs2 value for stores.
- req_rd  in  5  load destination register.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  DATA_WIDTH  word-aligned address ({req_addr[31:2],2'b00}).
- mem_we  out  1  write enable.
- mem_wstrb  out  4  byte-lane strobes.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_rsp_valid  in  1  read data valid; also the store acknowledge.
- mem_rdata  in  DATA_WIDTH  read word.
- wb_valid  out  1  one-cycle completion pulse; for loads it also means rd write.
- wb_is_load  out  1  qualifies wb_rd/wb_data.
- wb_rd  out  5  destination register.
- wb_data  out  DATA_WIDTH  extended load result.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  2  0 misaligned load, 1 misaligned store, 2 illegal funct3, 3 bus timeout.
- exc_addr  out  DATA_WIDTH  faulting effective address.

Behaviour:
- Reset: state=IDLE; req_ready=1; every other output 0.
  - Reset mid-transaction abandons it; any late mem_rsp_valid seen in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE:
  - Accepts on req_valid && req_ready and registers all req_* fields.
  - Decode at accept:
    - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Stores: 000 SB, 001 SH, 010 SW.
    - Any other funct3 -> FAULT, cause 2.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
    - Violation -> FAULT, cause 0 or 1.
    - No memory access is made.
  - Otherwise -> REQ.
- REQ:
  - mem_req_valid=1 with registered mem_addr/mem_we/mem_wstrb/mem_wdata, held stable until mem_req_ready.
  - Handshake cycle -> WAIT.
- WAIT:
  - Waits for mem_rsp_valid; stores also wait for it as the write acknowledge.
  - mem_rsp_valid arriving in the same cycle as the request handshake is not sampled; the memory must respond at least one cycle later.
  - On mem_rsp_valid -> DONE; load data is latched after lane select and extension.
- DONE:
  - wb_valid=1 for exactly one cycle; wb_is_load and wb_rd as registered; wb_data=0 for stores.
  - -> IDLE.
- FAULT:
  - exc_valid=1 for one cycle with exc_cause and exc_addr; wb_valid stays 0.
  - -> IDLE.
- Minimum latency: accept(0), REQ(1), WAIT(2), DONE(3), so wb_valid is at the earliest 3 cycles after accept.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{b}}.
  - SH: wstrb = 0011 or 1100, wdata = {2{h}}.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- req_ready is low in all non-IDLE states; a back-to-back request is accepted in the cycle after the DONE/FAULT pulse.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments every cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES with no completing handshake -> FAULT, cause 3, and mem_req_valid drops.
- Undefined:
  - No counter logic; the LSU waits indefinitely and cause 3 is never produced.

Decomposition:
- Package lsu_pkg holds:
  - state enum lsu_state_t;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - exception cause enum lsu_exc_t.
- Sub-module lsu_load_align (combinational): inputs rdata, addr[1:0], funct3; output extended word. Instantiated once.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, memory ready immediately, ack 1 cycle later -> mem_addr 0x100, wstrb 1111; wb_valid pulse with wb_is_load=0 three cycles after accept.
- LB addr 0x203 with rdata 0x80FF_1234 -> wb_data 0xFFFFFF80, wb_rd as issued; LBU at the same address -> 0x00000080.
- SH addr 0x2 with wdata 0x0000ABCD -> wstrb 1100, mem_wdata 0xABCDABCD; LH addr 0x1 -> exc_valid, cause 0, exc_addr 0x1, and no mem_req_valid.
- Funct3 011 load -> FAULT cause 2; then an immediate LW is accepted the next cycle and completes normally.
- mem_req_ready held low 5 cycles, then rst asserted in WAIT -> all outputs 0 and req_ready=1 the following cycle; a stray mem_rsp_valid in IDLE produces no wb_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response to a load -> exc_valid cause 3 exactly 8 cycles after entering REQ.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types, constants and helpers for the load/store unit.
//
// Contents:
//   lsu_state_t  : FSM state encoding (IDLE, REQ, WAIT, DONE, FAULT)
//   F3_*         : RV32I funct3 width/sign encodings for loads and stores
//   lsu_exc_t    : exception cause codes reported on exc_cause
//   f3_legal, f3_misaligned, store_strobe, store_data : decode helpers
//
// The datapath is fixed at 32 bits with four byte lanes.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAULT = 3'd4
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      EXC_LOAD_MISALIGN  = 2'd0,
      EXC_STORE_MISALIGN = 2'd1,
      EXC_ILLEGAL_F3     = 2'd2,
      EXC_TIMEOUT        = 2'd3
   } lsu_exc_t;

   // Stores only exist in B/H/W flavours; the unsigned forms are load-only.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok_v;
      case (f3)
         F3_B, F3_H, F3_W: ok_v = 1'b1;
         F3_BU, F3_HU:     ok_v = ~is_store;
         default:          ok_v = 1'b0;
      endcase
      return ok_v;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis_v;
      case (f3)
         F3_H, F3_HU: mis_v = lo[0];
         F3_W:        mis_v = (lo != 2'b00);
         default:     mis_v = 1'b0;
      endcase
      return mis_v;
   endfunction

   function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lo);
      logic [3:0] strb_v;
      case (f3)
         F3_B:    strb_v = 4'b0001 << lo;
         F3_H:    strb_v = lo[1] ? 4'b1100 : 4'b0011;
         F3_W:    strb_v = 4'b1111;
         default: strb_v = 4'b0000;
      endcase
      return strb_v;
   endfunction

   // Replicating the datum across lanes lets the strobes alone pick the target bytes.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
      logic [31:0] d_v;
      case (f3)
         F3_B:    d_v = {4{wdata[7:0]}};
         F3_H:    d_v = {2{wdata[15:0]}};
         default: d_v = wdata;
      endcase
      return d_v;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if -- data-memory bus between the load/store unit and memory.
//
// Signals:
//   mem_req_valid / mem_req_ready : request handshake
//   mem_addr, mem_we, mem_wstrb, mem_wdata : request payload (word-aligned)
//   mem_rsp_valid, mem_rdata : response (also the store acknowledge)
// Modports: master (LSU side), slave (memory side).
interface lsu_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [3:0]            mem_wstrb;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_rsp_valid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align -- combinational lane select and sign/zero extension of load data.
//
// Ports:
//   rdata    in  32  raw word returned by memory
//   addr_lo  in  2   low effective-address bits selecting the lane
//   funct3   in  3   load width/sign encoding
//   data_out out 32  extended result for writeback
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data_out
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
   assign half_s = rdata[{addr_lo[1], 4'b0000} +: 16];

   // Width select and extension.
   always_comb begin
      data_out = 32'h0000_0000;
      case (funct3)
         F3_B:    data_out = {{24{byte_s[7]}}, byte_s};
         F3_H:    data_out = {{16{half_s[15]}}, half_s};
         F3_W:    data_out = rdata;
         F3_BU:   data_out = {24'h00_0000, byte_s};
         F3_HU:   data_out = {16'h0000, half_s};
         default: data_out = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- memory-stage LSU: one data-memory transaction at a time.
//
// Build option: define LSU_TIMEOUT_EN to enable the response watchdog
// (TIMEOUT_CYCLES cycles in REQ/WAIT -> exception cause 3).
//
// Ports:
//   clk, rst (sync, active-high)
//   req_*  : request from execute (valid/ready, store flag, funct3, addr, wdata, rd)
//   mem    : lsu_if.master data-memory bus
//   wb_*   : one-cycle completion pulse with load result
//   exc_*  : one-cycle exception pulse with cause and faulting address
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [4:0]            req_rd,
   lsu_if.master                 mem,
   output logic                  wb_valid,
   output logic                  wb_is_load,
   output logic [4:0]            wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  exc_valid,
   output logic [1:0]            exc_cause,
   output logic [DATA_WIDTH-1:0] exc_addr
);

   lsu_state_t            state_r, state_s;
   logic                  is_store_r;
   logic [2:0]            funct3_r;
   logic [DATA_WIDTH-1:0] addr_r;
   logic [4:0]            rd_r;

   logic                  req_ready_r;
   logic                  mem_req_valid_r;
   logic [DATA_WIDTH-1:0] mem_addr_r;
   logic                  mem_we_r;
   logic [3:0]            mem_wstrb_r;
   logic [DATA_WIDTH-1:0] mem_wdata_r;
   logic                  wb_valid_r;
   logic                  wb_is_load_r;
   logic [4:0]            wb_rd_r;
   logic [DATA_WIDTH-1:0] wb_data_r;
   logic                  exc_valid_r;
   lsu_exc_t              exc_cause_r;
   logic [DATA_WIDTH-1:0] exc_addr_r;

   logic                  dec_legal_s;
   logic                  dec_misalign_s;
   lsu_exc_t              exc_cause_s;
   logic [DATA_WIDTH-1:0] exc_addr_s;
   logic [DATA_WIDTH-1:0] load_data_s;
   logic                  timeout_s;

   assign dec_legal_s    = f3_legal(req_is_store, req_funct3);
   assign dec_misalign_s = f3_misaligned(req_funct3, req_addr[1:0]);

   lsu_load_align u_align (
      .rdata    (mem.mem_rdata),
      .addr_lo  (addr_r[1:0]),
      .funct3   (funct3_r),
      .data_out (load_data_s)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_r;

   // Watchdog: zero in the first REQ cycle, so the fault lands TIMEOUT_CYCLES after REQ entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= '0;
      end else if ((state_s == ST_REQ) && (state_r != ST_REQ)) begin
         tmo_cnt_r <= '0;
      end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   assign timeout_s = (tmo_cnt_r == TMO_LAST);
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state decode plus the cause/address to report if FAULT is entered.
   always_comb begin
      state_s     = state_r;
      exc_cause_s = EXC_ILLEGAL_F3;
      exc_addr_s  = addr_r;
      case (state_r)
         ST_IDLE: begin
            exc_addr_s = req_addr;
            if (req_valid) begin
               if (!dec_legal_s) begin
                  state_s     = ST_FAULT;
                  exc_cause_s = EXC_ILLEGAL_F3;
               end else if (dec_misalign_s) begin
                  state_s = ST_FAULT;
                  if (req_is_store) begin
                     exc_cause_s = EXC_STORE_MISALIGN;
                  end else begin
                     exc_cause_s = EXC_LOAD_MISALIGN;
                  end
               end else begin
                  state_s = ST_REQ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            // A completing handshake wins over a simultaneous watchdog expiry.
            if (mem.mem_req_ready) begin
               state_s = ST_WAIT;
            end else if (timeout_s) begin
               state_s     = ST_FAULT;
               exc_cause_s = EXC_TIMEOUT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem.mem_rsp_valid) begin
               state_s = ST_DONE;
            end else if (timeout_s) begin
               state_s     = ST_FAULT;
               exc_cause_s = EXC_TIMEOUT;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE:  state_s = ST_IDLE;
         ST_FAULT: state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State register and all registered outputs, derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= ST_IDLE;
         is_store_r      <= 1'b0;
         funct3_r        <= 3'b000;
         addr_r          <= '0;
         rd_r            <= 5'd0;
         req_ready_r     <= 1'b1;
         mem_req_valid_r <= 1'b0;
         mem_addr_r      <= '0;
         mem_we_r        <= 1'b0;
         mem_wstrb_r     <= 4'b0000;
         mem_wdata_r     <= '0;
         wb_valid_r      <= 1'b0;
         wb_is_load_r    <= 1'b0;
         wb_rd_r         <= 5'd0;
         wb_data_r       <= '0;
         exc_valid_r     <= 1'b0;
         exc_cause_r     <= EXC_LOAD_MISALIGN;
         exc_addr_r      <= '0;
      end else begin
         state_r         <= state_s;
         req_ready_r     <= (state_s == ST_IDLE);
         mem_req_valid_r <= (state_s == ST_REQ);
         wb_valid_r      <= (state_s == ST_DONE);
         exc_valid_r     <= (state_s == ST_FAULT);

         // Request fields and bus payload are captured once at accept and held.
         if ((state_r == ST_IDLE) && req_valid) begin
            is_store_r  <= req_is_store;
            funct3_r    <= req_funct3;
            addr_r      <= req_addr;
            rd_r        <= req_rd;
            mem_addr_r  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
            mem_we_r    <= req_is_store;
            mem_wstrb_r <= req_is_store ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
            mem_wdata_r <= req_is_store ? store_data(req_funct3, req_wdata) : '0;
         end else begin
            is_store_r  <= is_store_r;
            funct3_r    <= funct3_r;
            addr_r      <= addr_r;
            rd_r        <= rd_r;
            mem_addr_r  <= mem_addr_r;
            mem_we_r    <= mem_we_r;
            mem_wstrb_r <= mem_wstrb_r;
            mem_wdata_r <= mem_wdata_r;
         end

         // Writeback fields are only non-zero during the DONE pulse.
         if (state_s == ST_DONE) begin
            wb_is_load_r <= ~is_store_r;
            wb_rd_r      <= rd_r;
            wb_data_r    <= is_store_r ? '0 : load_data_s;
         end else begin
            wb_is_load_r <= 1'b0;
            wb_rd_r      <= 5'd0;
            wb_data_r    <= '0;
         end

         if (state_s == ST_FAULT) begin
            exc_cause_r <= exc_cause_s;
            exc_addr_r  <= exc_addr_s;
         end else begin
            exc_cause_r <= EXC_LOAD_MISALIGN;
            exc_addr_r  <= '0;
         end
      end
   end

   assign req_ready         = req_ready_r;
   assign mem.mem_req_valid = mem_req_valid_r;
   assign mem.mem_addr      = mem_addr_r;
   assign mem.mem_we        = mem_we_r;
   assign mem.mem_wstrb     = mem_wstrb_r;
   assign mem.mem_wdata     = mem_wdata_r;
   assign wb_valid          = wb_valid_r;
   assign wb_is_load        = wb_is_load_r;
   assign wb_rd             = wb_rd_r;
   assign wb_data           = wb_data_r;
   assign exc_valid         = exc_valid_r;
   assign exc_cause         = exc_cause_r;
   assign exc_addr          = exc_addr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed self-checking bench for load_store_unit.
// Memory side is driven directly by the directed steps.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
   localparam int TB_TMO = 8;
`else
   localparam int TB_TMO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        wb_valid;
   logic        wb_is_load;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_if #(.DATA_WIDTH(32)) mem_bus ();

   load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .mem          (mem_bus.master),
      .wb_valid     (wb_valid),
      .wb_is_load   (wb_is_load),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .exc_valid    (exc_valid),
      .exc_cause    (exc_cause),
      .exc_addr     (exc_addr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_req_ready"}, req_ready, 32'd1);
      check({tag, "_mem_req_valid"}, mem_bus.mem_req_valid, 32'd0);
      check({tag, "_mem_addr"}, mem_bus.mem_addr, 32'd0);
      check({tag, "_mem_we"}, mem_bus.mem_we, 32'd0);
      check({tag, "_mem_wstrb"}, mem_bus.mem_wstrb, 32'd0);
      check({tag, "_mem_wdata"}, mem_bus.mem_wdata, 32'd0);
      check({tag, "_wb_valid"}, wb_valid, 32'd0);
      check({tag, "_wb_is_load"}, wb_is_load, 32'd0);
      check({tag, "_wb_rd"}, wb_rd, 32'd0);
      check({tag, "_wb_data"}, wb_data, 32'd0);
      check({tag, "_exc_valid"}, exc_valid, 32'd0);
      check({tag, "_exc_cause"}, exc_cause, 32'd0);
      check({tag, "_exc_addr"}, exc_addr, 32'd0);
   endtask

   // Full transaction: ready at once, response one cycle after the handshake.
   task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_mwdata, input logic [31:0] exp_wb);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      mem_bus.mem_req_ready = 1'b1;
      step();                                   // cycle 1: REQ
      req_valid = 1'b0;
      check({tag, "_req_ready_busy"}, req_ready, 32'd0);
      check({tag, "_mem_req_valid"}, mem_bus.mem_req_valid, 32'd1);
      check({tag, "_mem_addr"}, mem_bus.mem_addr, exp_maddr);
      check({tag, "_mem_we"}, mem_bus.mem_we, {31'd0, st});
      check({tag, "_mem_wstrb"}, mem_bus.mem_wstrb, {28'd0, exp_strb});
      check({tag, "_mem_wdata"}, mem_bus.mem_wdata, exp_mwdata);
      step();                                   // cycle 2: WAIT
      mem_bus.mem_req_ready = 1'b0;
      mem_bus.mem_rsp_valid = 1'b1;
      mem_bus.mem_rdata = rdata;
      check({tag, "_mem_req_valid_drop"}, mem_bus.mem_req_valid, 32'd0);
      check({tag, "_wb_early"}, wb_valid, 32'd0);
      step();                                   // cycle 3: DONE
      mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_rdata = 32'h0000_0000;
      check({tag, "_wb_valid"}, wb_valid, 32'd1);
      check({tag, "_wb_is_load"}, wb_is_load, {31'd0, ~st});
      if (!st) begin
         check({tag, "_wb_rd"}, wb_rd, {27'd0, rd});
      end
      check({tag, "_wb_data"}, wb_data, exp_wb);
      check({tag, "_exc_valid"}, exc_valid, 32'd0);
      step();                                   // back in IDLE
      check({tag, "_wb_pulse_end"}, wb_valid, 32'd0);
      check({tag, "_req_ready_idle"}, req_ready, 32'd1);
   endtask

   // Request that must fault at accept without touching memory.
   task automatic run_fault(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [1:0] exp_cause);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_addr = addr; req_wdata = 32'h1234_5678; req_rd = 5'd9;
      step();                                   // FAULT
      req_valid = 1'b0;
      check({tag, "_exc_valid"}, exc_valid, 32'd1);
      check({tag, "_exc_cause"}, exc_cause, {30'd0, exp_cause});
      check({tag, "_exc_addr"}, exc_addr, addr);
      check({tag, "_no_mem_req"}, mem_bus.mem_req_valid, 32'd0);
      check({tag, "_no_wb"}, wb_valid, 32'd0);
      check({tag, "_req_ready_busy"}, req_ready, 32'd0);
      step();
      check({tag, "_exc_pulse_end"}, exc_valid, 32'd0);
      check({tag, "_req_ready_back"}, req_ready, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      step();
      step();
      check_idle_zero("reset");
      rst = 1'b0;
      step();

      // SW 0x100
      run_txn("sw", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 32'h0,
              32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      // LB / LBU from lane 3 of 0x80FF_1234
      run_txn("lb", 1'b0, 3'b000, 32'h0000_0203, 32'h0, 5'd7, 32'h80FF_1234,
              32'h0000_0200, 4'b0000, 32'h0, 32'hFFFF_FF80);
      run_txn("lbu", 1'b0, 3'b100, 32'h0000_0203, 32'h0, 5'd8, 32'h80FF_1234,
              32'h0000_0200, 4'b0000, 32'h0, 32'h0000_0080);
      // SH upper half, SB lane 1
      run_txn("sh", 1'b1, 3'b001, 32'h0000_0002, 32'h0000_ABCD, 5'd2, 32'h0,
              32'h0000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0);
      run_txn("sb", 1'b1, 3'b000, 32'h0000_0011, 32'h1234_56A5, 5'd2, 32'h0,
              32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      // LH upper half signed, LHU lower half
      run_txn("lh", 1'b0, 3'b001, 32'h0000_0032, 32'h0, 5'd12, 32'h8001_7FFF,
              32'h0000_0030, 4'b0000, 32'h0, 32'hFFFF_8001);
      run_txn("lhu", 1'b0, 3'b101, 32'h0000_0030, 32'h0, 5'd13, 32'h8001_F00F,
              32'h0000_0030, 4'b0000, 32'h0, 32'h0000_F00F);

      // Exceptions at accept
      run_fault("lh_mis", 1'b0, 3'b001, 32'h0000_0001, 2'd0);
      run_fault("sw_mis", 1'b1, 3'b010, 32'h0000_0102, 2'd1);
      run_fault("st_f3", 1'b1, 3'b100, 32'h0000_0020, 2'd2);
      run_fault("ld_f3", 1'b0, 3'b011, 32'h0000_0040, 2'd2);
      // LW issued right after the fault pulse
      run_txn("lw_after_fault", 1'b0, 3'b010, 32'h0000_0044, 32'h0, 5'd3, 32'h1234_5678,
              32'h0000_0044, 4'b0000, 32'h0, 32'h1234_5678);

      // Back-pressure for 5 cycles, then reset while in WAIT
      req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h0000_0300; req_rd = 5'd4;
      mem_bus.mem_req_ready = 1'b0;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_mem_req_valid", mem_bus.mem_req_valid, 32'd1);
         check("bp_mem_addr", mem_bus.mem_addr, 32'h0000_0300);
         if (i < 4) begin
            step();
         end
      end
      mem_bus.mem_req_ready = 1'b1;
      step();                                   // WAIT
      mem_bus.mem_req_ready = 1'b0;
      check("bp_wait_req_ready", req_ready, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_idle_zero("mid_reset");
      mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'hCAFE_F00D;
      step();
      mem_bus.mem_rsp_valid = 1'b0;
      check("stray_rsp_wb1", wb_valid, 32'd0);
      step();
      check("stray_rsp_wb2", wb_valid, 32'd0);
      check("stray_rsp_exc", exc_valid, 32'd0);
      check("stray_rsp_ready", req_ready, 32'd1);

      // Load that never gets a response
      req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h0000_0500; req_rd = 5'd5;
      mem_bus.mem_req_ready = 1'b1;
      step();                                   // first REQ cycle
      req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         step();
         mem_bus.mem_req_ready = 1'b0;
      end
      check("tmo_not_yet", exc_valid, 32'd0);
      step();                                   // 8 cycles after REQ entry
      check("tmo_exc_valid", exc_valid, 32'd1);
      check("tmo_exc_cause", exc_cause, 32'd3);
      check("tmo_exc_addr", exc_addr, 32'h0000_0500);
      check("tmo_mem_req_valid", mem_bus.mem_req_valid, 32'd0);
      check("tmo_no_wb", wb_valid, 32'd0);
      step();
      check("tmo_ready_back", req_ready, 32'd1);
`else
      for (int i = 0; i < 20; i++) begin
         step();
         mem_bus.mem_req_ready = 1'b0;
      end
      check("no_tmo_exc", exc_valid, 32'd0);
      check("no_tmo_still_busy", req_ready, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("no_tmo_reset_ready", req_ready, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
